// File: rtl/fetch_queue_pkg.sv
// Shared constants for the fetch/decode decoupling queue.
//   NOP_INSTR : instruction presented to decode when the queue is empty
//   INSTR_W   : instruction word width
//   PC_W      : word-address PC width, matching the fetch stage
package fetch_queue_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 30;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/fq_ptr.sv
// Wrap-around pointer for the fetch queue. The pointer rolls over naturally
// because DEPTH is a power of two.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : synchronous clear (flush), wins over inc_i
//   inc_i      : advance pointer by one
//   ptr_o      : current pointer value
module fq_ptr #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i)      ptr_d = '0;
    else if (inc_i) ptr_d = ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fetch_queue.sv
// First-word fall-through queue between instruction fetch and decode.
// Ports:
//   clk, rst_n                   : clock, asynchronous active-low reset
//   in_valid/in_instr/in_pc      : word offered by fetch
//   in_ready                     : queue can take a push (registered state only)
//   out_valid/out_instr/out_pc   : head entry; NOP/0 when empty
//   out_ready                    : decode consumes head
//   flush                        : taken branch/jump, discards everything
//   count                        : occupancy 0..DEPTH
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  output logic               in_ready,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  input  logic               out_ready,
  input  logic               flush,
  output logic [PTR_W:0]     count
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [INSTR_W-1:0] instr_q [DEPTH];
  logic [PC_W-1:0]    pc_q    [DEPTH];
  logic [PTR_W:0]     count_q, count_d;
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic               push, pop;

  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);

  // Flush voids any concurrent transfer.
  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  fq_ptr #(.W(PTR_W)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (flush),
    .inc_i (pop),
    .ptr_o (rd_ptr)
  );

  fq_ptr #(.W(PTR_W)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (flush),
    .inc_i (push),
    .ptr_o (wr_ptr)
  );

  always_comb begin
    count_d = count_q;
    if (flush)             count_d = '0;
    else if (push && !pop) count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  // Storage is never reset; the output mux below keeps stale or
  // uninitialised entries from reaching decode.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[wr_ptr] <= in_instr;
      pc_q[wr_ptr]    <= in_pc;
    end
  end

  assign out_instr = out_valid ? instr_q[rd_ptr] : NOP_INSTR;
  assign out_pc    = out_valid ? pc_q[rd_ptr]    : '0;
  assign count     = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [29:0] in_pc;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [29:0] out_pc;
  logic        out_ready;
  logic        flush;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: entries held as {instr, pc} in arrival order.
  logic [61:0] mq [$];

  fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .out_ready (out_ready),
    .flush     (flush),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [61:0] head;
    head = (mq.size() != 0) ? mq[0] : 62'h0;
    chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
    chk("count",     64'(count),     64'(mq.size()));
    chk("in_ready",  64'(in_ready),  64'(mq.size() < DEPTH));
    chk("out_instr", 64'(out_instr), 64'(head[61:30]));
    chk("out_pc",    64'(out_pc),    64'(head[29:0]));
  endtask

  // One clock: drive at the negedge, clock the model at the posedge,
  // check the settled outputs at the next negedge.
  task automatic cyc(input logic iv, input logic [31:0] ins, input logic [29:0] p,
                     input logic ordy, input logic fl, output logic acc);
    in_valid  = iv;
    in_instr  = ins;
    in_pc     = p;
    out_ready = ordy;
    flush     = fl;
    #1;
    // ready must not react to out_ready or any other input
    chk("in_ready_comb", 64'(in_ready), 64'(mq.size() < DEPTH));
    acc = iv && !fl && (mq.size() < DEPTH);
    @(posedge clk);
    if (fl) mq.delete();
    else begin
      if (mq.size() != 0 && ordy) void'(mq.pop_front());
      if (acc) mq.push_back({ins, p});
    end
    @(negedge clk);
    check_outputs();
  endtask

  function automatic logic [31:0] mk_instr(input logic [29:0] p);
    return 32'h2000_0000 ^ {2'b0, p} ^ 32'($urandom_range(0, 255) << 20);
  endfunction

  logic        acc;
  logic [29:0] hold_pc;
  logic [31:0] hold_instr;
  int          guard;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    out_ready = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_outputs();

    // single pass
    cyc(1'b1, 32'h2010_0005, 30'h10, 1'b0, 1'b0, acc);
    chk("single_pc", 64'(out_pc), 64'h10);
    cyc(1'b0, 32'h0, 30'h0, 1'b1, 1'b0, acc);

    // fill and back-pressure
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'hA000_0000 + 32'(i), 30'(i), 1'b0, 1'b0, acc);
    chk("fill_count", 64'(count), 64'd4);
    chk("fifth_rejected", 64'(acc), 64'd0);
    // fetch holds pc 4 while decode drains
    guard = 0;
    do begin
      cyc(1'b1, 32'hA000_0004, 30'd4, 1'b1, 1'b0, acc);
      guard++;
    end while (!acc && guard < 10);
    chk("pc4_accepted", 64'(acc), 64'd1);
    while (mq.size() != 0 && guard < 20) begin
      cyc(1'b0, 32'h0, 30'h0, 1'b1, 1'b0, acc);
      guard++;
    end

    // simultaneous push/pop at count 2, then steady-state wrap
    cyc(1'b1, 32'hB000_0100, 30'h100, 1'b0, 1'b0, acc);
    cyc(1'b1, 32'hB000_0101, 30'h101, 1'b0, 1'b0, acc);
    cyc(1'b1, 32'hB000_0102, 30'h102, 1'b1, 1'b0, acc);
    chk("pushpop_count", 64'(count), 64'd2);
    cyc(1'b0, 32'h0, 30'h0, 1'b1, 1'b0, acc);
    cyc(1'b0, 32'h0, 30'h0, 1'b1, 1'b0, acc);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 32'hC000_0000 + 32'(i), 30'(i), 1'b1, 1'b0, acc);
      chk("wrap_pc", 64'(out_pc), 64'(i));
    end
    cyc(1'b0, 32'h0, 30'h0, 1'b1, 1'b0, acc);

    // flush priority at count 3
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'hD000_0000 + 32'(i), 30'(i), 1'b0, 1'b0, acc);
    cyc(1'b1, 32'hDEAD_0020, 30'h20, 1'b1, 1'b1, acc);
    chk("flush_count", 64'(count), 64'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 32'h0, 30'h0, 1'b1, 1'b0, acc);
      chk("flush_no_pc20", 64'(out_pc == 30'h20), 64'd0);
    end
    cyc(1'b0, 32'h0, 30'h0, 1'b1, 1'b1, acc); // flush while empty

    // asynchronous reset between edges
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'hE000_0000 + 32'(i), 30'(i), 1'b0, 1'b0, acc);
    chk("pre_reset_count", 64'(count), 64'd3);
    in_valid = 1'b0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    mq.delete();
    chk("async_valid", 64'(out_valid), 64'd0);
    chk("async_count", 64'(count), 64'd0);
    chk("async_instr", 64'(out_instr), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 32'h1234_5678, 30'h33, 1'b0, 1'b0, acc);
    chk("post_reset_pc", 64'(out_pc), 64'h33);
    cyc(1'b0, 32'h0, 30'h0, 1'b1, 1'b0, acc);

    // randomized traffic; fetch holds its word until accepted or flushed
    hold_pc = 30'h1000;
    hold_instr = mk_instr(hold_pc);
    for (int i = 0; i < 600; i++) begin
      logic iv, ordy, fl;
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 24) == 0);
      cyc(iv, hold_instr, hold_pc, ordy, fl, acc);
      if (acc || fl) begin
        hold_pc = hold_pc + 30'(1 + (fl ? $urandom_range(0, 64) : 0));
        hold_instr = mk_instr(hold_pc);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before %0t", $time);
    $fatal(1);
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Decoupling buffer between instruction fetch and decode in the pipelined MIPS core.
- Captures each fetched word with its 30-bit word-address PC, and presents them in order to the decode stage over a valid/ready handshake.
- Absorbs decode stalls without freezing the PC.
- Discards all queued instructions on a taken branch/jump flush.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- PTR_W, 2, log2(DEPTH); pointer width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  fetch presents a word this cycle.
- in_instr  input  32  fetched instruction.
- in_pc  input  30  word address of in_instr.
- in_ready  output  1  queue accepts a push this cycle.
- out_valid  output  1  head entry is valid.
- out_instr  output  32  head instruction; NOP (32'h0000_0000) when empty.
- out_pc  output  30  head PC; 30'h0 when empty.
- out_ready  input  1  decode consumes the head this cycle.
- flush  input  1  taken branch/jump; discard all contents.
- count  output  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (rst_n low, asynchronous):
  - read pointer, write pointer and count go to 0.
  - out_valid = 0, out_instr = 32'h0, out_pc = 0, in_ready = 1 (once reset is released).
  - Storage contents are don't-care.
- Reset asserted mid-operation: all entries are lost immediately, without waiting for a clock edge.
- Push: occurs when in_valid && in_ready at the rising edge. The entry is written at the write pointer, and the write pointer increments modulo DEPTH.
- Pop: occurs when out_valid && out_ready at the rising edge. The read pointer increments modulo DEPTH.
- Output timing: first-word fall-through.
  - out_instr/out_pc are driven combinationally from the entry at the read pointer.
  - out_valid = (count != 0).
  - A word pushed at edge N is visible on out_* after edge N, so minimum latency is 1 cycle.
- Count update:
  - push only: count + 1.
  - pop only: count − 1.
  - push and pop together: count unchanged.
- in_ready = (count != DEPTH), derived from registered state only.
  - When full, a simultaneous pop does NOT enable a push in the same cycle. There is no combinational ready path from out_ready to in_ready.
- Empty: out_valid = 0 and out_* show NOP/0. out_ready is ignored, so the pointer never underflows.
- Full: in_ready = 0 and in_valid is ignored. The fetch stage must hold its word.
- Pointer wrap: pointers wrap from DEPTH−1 to 0. Full/empty is determined by count, not by pointer equality.
- Flush has priority over push and pop in the same cycle:
  - at the edge, read pointer, write pointer and count go to 0.
  - any concurrent push is dropped and any concurrent pop is void.
  - out_valid = 0 in the following cycle.
- Flush while empty: no effect beyond holding state at 0.
- No X may propagate to out_instr/out_pc while out_valid = 0.

Decomposition:
- Shared package constants:
  - NOP_INSTR = 32'h0000_0000.
  - PC_W = 30 (word-address PC width, matching the fetch stage).
  - INSTR_W = 32.
- One sub-module is natural: fq_ptr, a PTR_W-bit wrap-around counter with an increment enable and a synchronous clear (used for flush). It is instantiated twice, for the read and write pointers.
- Storage is a plain register array inside fetch_queue.

Test Plan:
- Reset then idle: rst_n = 0 for 2 cycles, then released → out_valid = 0, out_instr = 32'h0, count = 0, in_ready = 1.
- Single pass: push instr 32'h2010_0005 with pc 30'h10, out_ready = 0 → next cycle out_valid = 1, out_instr = 32'h2010_0005, out_pc = 30'h10, count = 1. Then pop → out_valid = 0, count = 0.
- Fill and back-pressure:
  - push 5 words (pc 0..4) with out_ready = 0 → count = 4, in_ready = 0 after the 4th push, and the 5th word is not accepted.
  - drain with out_ready = 1 → pc 0, 1, 2, 3 emerge in order, then the fetch word with pc 4 is accepted.
- Simultaneous push/pop at count = 2 → count stays 2 and order is preserved. Wrap check: 10 pushes and pops in steady state → PCs emerge as 0..9 with no gaps.
- Flush priority: with count = 3, assert flush together with in_valid = 1 (pc 30'h20) and out_ready = 1 → next cycle count = 0, out_valid = 0, and pc 30'h20 never appears on out_pc.
- Asynchronous reset mid-stream: with count = 3, drop rst_n between edges → out_valid falls without a clock edge, count = 0, and after release the first push appears correctly.
